// File: rtl/pb_scan_debouncer_if.sv
// Push-button debouncer bundle: raw pins in, debounced levels and edge strobes out.
interface pb_scan_debouncer_if #(
  parameter int NUM_PB = 4
);
  logic [NUM_PB-1:0] PB;
  logic [NUM_PB-1:0] pb_state;
  logic [NUM_PB-1:0] pb_rise;
  logic [NUM_PB-1:0] pb_fall;
  logic              busy;
  logic [2:0]        active_idx;

  modport master (output PB, input pb_state, pb_rise, pb_fall, busy, active_idx);
  modport slave  (input PB, output pb_state, pb_rise, pb_fall, busy, active_idx);
endinterface

// File: rtl/pb_scan_debouncer.sv
// Debounces NUM_PB buttons with one shared counter granted round-robin to
// whichever button's synchronized level disagrees with its committed level.

module pb_sync_lane (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  input  logic level,
  output logic pending
);
  logic sync0, sync1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= pin;
      sync1 <= sync0;
    end
  end

  assign pending = sync1 ^ level;
endmodule

module pb_scan_debouncer #(
  parameter int NUM_PB          = 4,
  parameter int DEBOUNCE_CYCLES = 6000000,
  parameter int CNT_W           = 27
) (
  input  logic                  clk,
  input  logic                  rst,
  pb_scan_debouncer_if.slave    bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {S_IDLE, S_COUNT} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [2:0]        ptr, ptr_nx, idx, idx_nx;
  logic [NUM_PB-1:0] st, st_nx, rise, rise_nx, fall, fall_nx;
  logic [NUM_PB-1:0] pending;
  logic              found, cur_pend;
  logic [2:0]        win, idx_inc;

  for (genvar g = 0; g < NUM_PB; g++) begin : g_lane
    pb_sync_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .pin    (bus.PB[g]),
      .level  (st[g]),
      .pending(pending[g])
    );
  end

  // Walk from ptr backwards-in-priority so the nearest pending index wins last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = NUM_PB - 1; k >= 0; k--) begin
      for (int i = 0; i < NUM_PB; i++) begin
        if (i == ((int'(ptr) + k) % NUM_PB) && pending[i]) begin
          found = 1'b1;
          win   = 3'(i);
        end
      end
    end
  end

  always_comb begin
    cur_pend = 1'b0;
    idx_inc  = '0;
    for (int i = 0; i < NUM_PB; i++) begin
      if (idx == 3'(i)) begin
        cur_pend = pending[i];
        idx_inc  = 3'((i + 1) % NUM_PB);
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ptr_nx   = ptr;
    idx_nx   = idx;
    st_nx    = st;
    rise_nx  = '0;
    fall_nx  = '0;
    case (state)
      S_IDLE: begin
        if (found) begin
          idx_nx   = win;
          cnt_nx   = '0;
          state_nx = S_COUNT;
        end
      end
      S_COUNT: begin
        // Bounce-back wins over a same-cycle commit.
        if (!cur_pend) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
          ptr_nx   = idx_inc;
        end else if (cnt == LAST) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
          ptr_nx   = idx_inc;
          for (int i = 0; i < NUM_PB; i++) begin
            if (idx == 3'(i)) begin
              st_nx[i]   = ~st[i];
              rise_nx[i] = ~st[i];
              fall_nx[i] = st[i];
            end
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      ptr   <= '0;
      idx   <= '0;
      st    <= '0;
      rise  <= '0;
      fall  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ptr   <= ptr_nx;
      idx   <= idx_nx;
      st    <= st_nx;
      rise  <= rise_nx;
      fall  <= fall_nx;
    end
  end

  assign bus.pb_state   = st;
  assign bus.pb_rise    = rise;
  assign bus.pb_fall    = fall;
  assign bus.busy       = (state == S_COUNT);
  assign bus.active_idx = idx;
endmodule
